// File: rtl/pipeline_pkg.sv
// Shared types and constants for the register/ALU/memory pipeline and its issue controller.
package pipeline_pkg;

    localparam int NREGS  = 16;
    localparam int REG_W  = $clog2(NREGS);
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [REG_W-1:0] FN_ADD = 4'd0;
    localparam logic [REG_W-1:0] FN_SUB = 4'd1;
    localparam logic [REG_W-1:0] FN_MUL = 4'd2;
    localparam logic [REG_W-1:0] FN_SLA = 4'd11;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } issue_state_e;

endpackage

// File: rtl/pipeline_issue_fifo.sv
// Synchronous instruction buffer; head is registered (no bypass from push to head).
module pipeline_issue_fifo
    import pipeline_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  instr_t                      din_i,
    output instr_t                      head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    instr_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full blocks the push even when a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// In-order issue controller with RAW-hazard bubbles for a non-forwarding pipeline.
// Optional stall counter output enabled by defining PIPE_ISSUE_STATS_EN.
module pipeline_issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WB_LAT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic              iss_vld,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [REG_W-1:0]  iss_func,
    output logic [ADDR_W-1:0] iss_addr,
`ifdef PIPE_ISSUE_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    localparam int SB_N  = (WB_LAT > 1) ? WB_LAT - 1 : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    instr_t                       in_instr;
    instr_t                       head;
    instr_t                       iss_q, iss_d;
    logic                         iss_vld_q;
    logic                         full, empty;
    logic [CNT_W-1:0]             count;
    logic                         push, pop, hazard, iss_next_vld, drain;
    logic [SB_N-1:0]              sb_vld_q;
    logic [SB_N-1:0][REG_W-1:0]   sb_rd_q;
    issue_state_e                 state_q, state_d;

    assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_rdy   = !full;
    assign push     = in_vld && in_rdy;

    pipeline_issue_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (in_instr),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // NOTE: assign every always_comb output a default first so no path infers a latch.
    always_comb begin
        hazard = 1'b0;
        if (WB_LAT > 1 && !empty) begin
            for (int i = 0; i < SB_N; i++) begin
                if (sb_vld_q[i] && (head.rs1 == sb_rd_q[i] || head.rs2 == sb_rd_q[i])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign iss_next_vld = !empty && !hazard && !flush;
    assign pop          = iss_next_vld;
    assign iss_d        = iss_next_vld ? head : '0;
    assign drain        = pop && !push && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_q     <= '0;
            iss_vld_q <= 1'b0;
            sb_vld_q  <= '0;
            sb_rd_q   <= '0;
        end else begin
            iss_q       <= iss_d;
            iss_vld_q   <= iss_next_vld;
            sb_vld_q[0] <= iss_next_vld;
            sb_rd_q[0]  <= head.rd;
            for (int i = 1; i < SB_N; i++) begin
                sb_vld_q[i] <= sb_vld_q[i-1];
                sb_rd_q[i]  <= sb_rd_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (push) state_d = ISSUE;
                ISSUE:   if (hazard) state_d = STALL;
                         else if (drain) state_d = IDLE;
                STALL:   if (!hazard) state_d = drain ? IDLE : ISSUE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // IDLE is held exactly while the buffer is empty, so it doubles as the empty flag here.
    assign busy = (state_q != IDLE) || ((WB_LAT > 1) && (|sb_vld_q));

    assign iss_vld  = iss_vld_q;
    assign iss_rs1  = iss_q.rs1;
    assign iss_rs2  = iss_q.rs2;
    assign iss_rd   = iss_q.rd;
    assign iss_func = iss_q.func;
    assign iss_addr = iss_q.addr;

`ifdef PIPE_ISSUE_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) stall_cnt_q <= '0;
        else if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: directed scenarios then random traffic, all against a queue-based model.
module tb_pipeline_issue_ctrl;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;
    localparam int WBL   = 3;

    logic       clk = 1'b0;
    logic       rst_n, in_vld, in_rdy, flush, iss_vld, busy;
    logic [3:0] in_rs1, in_rs2, in_rd, in_func;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] in_addr, iss_addr;
`ifdef PIPE_ISSUE_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: buffered instructions, and (rd, edge) of every recent issue.
    instr_t     mq[$];
    int         hist_e[$];
    logic [3:0] hist_rd[$];
    logic       e_vld   = 1'b0;
    instr_t     e_iss   = '0;
    logic       e_busy  = 1'b0;
    logic [15:0] e_stall = '0;

    always #5 clk = ~clk;

    pipeline_issue_ctrl #(.FIFO_DEPTH(DEPTH), .WB_LAT(WBL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rd    (in_rd),
        .in_func  (in_func),
        .in_addr  (in_addr),
        .flush    (flush),
        .iss_vld  (iss_vld),
        .iss_rs1  (iss_rs1),
        .iss_rs2  (iss_rs2),
        .iss_rd   (iss_rd),
        .iss_func (iss_func),
        .iss_addr (iss_addr),
`ifdef PIPE_ISSUE_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                  input logic [3:0] func, input int addr);
        mk = '{rs1: 4'(rs1), rs2: 4'(rs2), rd: 4'(rd), func: func, addr: 8'(addr)};
    endfunction

    // One clock edge of the reference behaviour, using the pre-edge model state.
    task automatic model_edge(input logic r, input logic v, input instr_t ins, input logic f);
        logic   can_push, hz;
        instr_t h;
        cyc++;
        if (!r) begin
            mq.delete();
            hist_e.delete();
            hist_rd.delete();
            e_vld   = 1'b0;
            e_iss   = '0;
            e_stall = '0;
        end else begin
            can_push = (mq.size() < DEPTH);
            hz = 1'b0;
            if (mq.size() > 0) begin
                h = mq[0];
                foreach (hist_e[i])
                    if (cyc - hist_e[i] < WBL && (hist_rd[i] == h.rs1 || hist_rd[i] == h.rs2))
                        hz = 1'b1;
            end
            if (f) begin
                mq.delete();
                e_vld   = 1'b0;
                e_iss   = '0;
                e_stall = '0;
            end else begin
                if (mq.size() > 0 && !hz) begin
                    e_iss = mq.pop_front();
                    e_vld = 1'b1;
                    hist_e.push_back(cyc);
                    hist_rd.push_back(e_iss.rd);
                end else begin
                    e_vld = 1'b0;
                    e_iss = '0;
                end
                if (hz && e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
                if (v && can_push) mq.push_back(ins);
            end
        end
        while (hist_e.size() > 0 && cyc - hist_e[0] >= WBL) begin
            void'(hist_e.pop_front());
            void'(hist_rd.pop_front());
        end
        e_busy = (mq.size() > 0);
        foreach (hist_e[i])
            if (cyc - hist_e[i] <= WBL - 2) e_busy = 1'b1;
    endtask

    task automatic check_outputs();
        check("iss_vld", 32'(iss_vld), 32'(e_vld));
        check("iss_fields", 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(e_iss));
        check("busy", 32'(busy), 32'(e_busy));
        check("in_rdy", 32'(in_rdy), 32'(mq.size() < DEPTH));
`ifdef PIPE_ISSUE_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
`endif
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic r, input logic v, input instr_t ins, input logic f);
        rst_n   = r;
        in_vld  = v;
        in_rs1  = ins.rs1;
        in_rs2  = ins.rs2;
        in_rd   = ins.rd;
        in_func = ins.func;
        in_addr = ins.addr;
        flush   = f;
        model_edge(r, v, ins, f);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    // Holds in_vld until the model says the buffer has room; bounded wait.
    task automatic push_hold(input instr_t ins);
        logic accepted;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = (mq.size() < DEPTH);
            step(1'b1, 1'b1, ins, 1'b0);
        end
        if (!accepted) check("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; flush = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_func = '0; in_addr = '0;
        @(negedge clk);

        // Reset held with in_vld high: nothing may be accepted.
        step(1'b0, 1'b1, mk(1, 2, 3, FN_ADD, 9), 1'b0);
        step(1'b0, 1'b1, mk(1, 2, 3, FN_ADD, 9), 1'b0);
        idle(2);

        // Independent back-to-back stream.
        step(1'b1, 1'b1, mk(3, 5, 10, FN_ADD, 125), 1'b0);
        step(1'b1, 1'b1, mk(3, 8, 12, FN_MUL, 126), 1'b0);
        idle(5);

        // RAW dependency: two bubbles between producer and consumer.
        step(1'b1, 1'b1, mk(3, 5, 10, FN_ADD, 125), 1'b0);
        step(1'b1, 1'b1, mk(10, 5, 14, FN_SUB, 127), 1'b0);
        idle(6);

        // Backpressure: dependent chain fills the buffer.
        push_hold(mk(0, 0, 1, FN_ADD, 1));
        for (int k = 1; k <= 5; k++) push_hold(mk(k, k, k + 1, FN_SLA, k + 1));
        idle(20);

        // Flush with entries buffered, one just issued, and a simultaneous push.
        step(1'b1, 1'b1, mk(0, 0, 5, FN_ADD, 40), 1'b0);
        step(1'b1, 1'b1, mk(5, 1, 6, FN_ADD, 41), 1'b0);
        step(1'b1, 1'b1, mk(6, 1, 7, FN_ADD, 42), 1'b0);
        step(1'b1, 1'b1, mk(7, 1, 8, FN_ADD, 43), 1'b0);
        step(1'b1, 1'b1, mk(2, 2, 9, FN_ADD, 44), 1'b1);
        idle(4);

        // Reset while a consumer is stalled.
        step(1'b1, 1'b1, mk(0, 0, 7, FN_MUL, 60), 1'b0);
        step(1'b1, 1'b1, mk(7, 0, 8, FN_SUB, 61), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(5);

        // Random traffic with a small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 7),
                 mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    4'($urandom_range(0, 15)), $urandom_range(0, 255)),
                 ($urandom_range(0, 32) == 0));
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
